// File: rtl/systolic_tile_ctrl.sv
// Tile scheduler for a weight-stationary systolic MAC array.
// Walks output-column and reduction tiles, skews activations, collects results.
module systolic_tile_ctrl #(
   parameter int LEN     = 5,
   parameter int WIDTH   = 4,
   parameter int BW_ACT  = 8,
   parameter int BW_WET  = 8,
   parameter int BW_ACCU = 32,
   parameter int IA_H    = 100,
   parameter int IA_W    = 150,
   parameter int OA_W    = 16,
   parameter int RES_LAT = 6,
   parameter int ROW_W   = $clog2(IA_H),
   parameter int COL_W   = $clog2(IA_W)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          wet_rd_en,
   output logic [COL_W-1:0]              wet_rd_row,
   output logic [COL_W-1:0]              wet_rd_col,
   input  logic [LEN*WIDTH*BW_WET-1:0]   wet_rd_data,
   output logic [LEN-1:0]                act_rd_en,
   output logic [LEN*ROW_W-1:0]          act_rd_row,
   output logic [COL_W-1:0]              act_rd_col,
   input  logic [LEN*BW_ACT-1:0]         act_rd_data,
   output logic                          pe_mac_enable,
   output logic                          pe_clear_acc,
   output logic [LEN*BW_ACT-1:0]         pe_act_in,
   output logic [LEN*WIDTH*BW_WET-1:0]   pe_wet_in,
   input  logic [WIDTH*BW_ACCU-1:0]      pe_result_in,
   output logic [WIDTH-1:0]              out_wr_en,
   output logic [WIDTH*ROW_W-1:0]        out_wr_row,
   output logic [COL_W-1:0]              out_wr_col,
   output logic                          out_wr_accum,
   output logic [WIDTH*BW_ACCU-1:0]      out_wr_data
);

   localparam int TM       = OA_W / WIDTH;
   localparam int TI       = IA_W / LEN;
   localparam int P        = RES_LAT + IA_H + WIDTH + 2;
   localparam int CW       = $clog2(P);
   localparam int FEED_END = IA_H + LEN - 1;
   localparam int COL_BEG  = RES_LAT + 2;
   localparam int COL_END  = P - 2;

   typedef enum logic [2:0] {
      IDLE, WLOAD, FEED, DRAIN, CLEAR, DONE, ACLR
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [COL_W-1:0]  m_q, i_q;
   logic              wet_en_q;
   logic [LEN-1:0]    act_en_q;
   logic              last_tile;
   logic              run;
   logic              coll;
   int                j;
   int                s;

   assign last_tile = (m_q == COL_W'(TM - 1)) && (i_q == COL_W'(TI - 1));
   assign run       = (state_q == FEED) || (state_q == DRAIN);
   assign j         = int'(cyc_q) - 1;
   assign s         = int'(cyc_q) - COL_BEG;
   assign coll      = run && (s >= 0) && (int'(cyc_q) <= COL_END);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign out_wr_data = pe_result_in;

   // State, step counter and tile indices.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         m_q     <= '0;
         i_q     <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         if (abort && state_q != IDLE) begin
            m_q <= '0;
            i_q <= '0;
         end else if (state_q == CLEAR) begin
            if (i_q == COL_W'(TI - 1)) begin
               i_q <= '0;
               m_q <= (m_q == COL_W'(TM - 1)) ? '0 : m_q + 1'b1;
            end else begin
               i_q <= i_q + 1'b1;
            end
         end
      end
   end

   // Next-state sequencing through one tile; abort diverts to a clear cycle.
   always_comb begin
      state_d = state_q;
      cyc_d   = '0;
      unique case (state_q)
         IDLE:  if (start && !abort) state_d = WLOAD;
         WLOAD: begin
            state_d = FEED;
            cyc_d   = cyc_q + 1'b1;
         end
         FEED: begin
            cyc_d = cyc_q + 1'b1;
            if (int'(cyc_q) == FEED_END) state_d = DRAIN;
         end
         DRAIN: begin
            cyc_d = cyc_q + 1'b1;
            if (int'(cyc_q) == COL_END) state_d = CLEAR;
         end
         CLEAR: state_d = last_tile ? DONE : WLOAD;
         DONE:  state_d = IDLE;
         ACLR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE && state_q != ACLR) begin
         state_d = ACLR;
         cyc_d   = '0;
      end
   end

   // Read requests, array control and write strobes decoded from the step.
   always_comb begin
      wet_rd_en     = 1'b0;
      wet_rd_row    = '0;
      wet_rd_col    = '0;
      act_rd_en     = '0;
      act_rd_row    = '0;
      act_rd_col    = '0;
      out_wr_en     = '0;
      out_wr_row    = '0;
      out_wr_col    = '0;
      out_wr_accum  = 1'b0;
      pe_mac_enable = run && (cyc_q >= CW'(2)) && (int'(cyc_q) <= COL_END);
      pe_clear_acc  = (state_q == CLEAR) || (state_q == ACLR);
      if (state_q == WLOAD) begin
         wet_rd_en  = 1'b1;
         wet_rd_row = COL_W'(int'(i_q) * LEN);
         wet_rd_col = COL_W'(int'(m_q) * WIDTH);
      end
      if (state_q == FEED) begin
         act_rd_col = COL_W'(int'(i_q) * LEN);
         for (int n = 0; n < LEN; n++) begin
            if (j >= n && j <= n + IA_H - 1) begin
               act_rd_en[n] = 1'b1;
               act_rd_row[n*ROW_W +: ROW_W] = ROW_W'(j - n);
            end
         end
      end
      if (coll) begin
         out_wr_col   = COL_W'(int'(m_q) * WIDTH);
         out_wr_accum = (i_q != '0);
         for (int p = 0; p < WIDTH; p++) begin
            if (s >= p && s <= p + IA_H - 1) begin
               out_wr_en[p] = 1'b1;
               out_wr_row[p*ROW_W +: ROW_W] = ROW_W'(s - p);
            end
         end
      end
   end

   // Track read-data validity and hold the weight block for the tile.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wet_en_q  <= 1'b0;
         act_en_q  <= '0;
         pe_wet_in <= '0;
      end else begin
         wet_en_q <= wet_rd_en;
         act_en_q <= act_rd_en;
         if (wet_en_q) pe_wet_in <= wet_rd_data;
      end
   end

   // Skewed activations: lanes without a valid read are zeroed.
   always_comb begin
      pe_act_in = '0;
      for (int n = 0; n < LEN; n++) begin
         if (act_en_q[n]) pe_act_in[n*BW_ACT +: BW_ACT] = act_rd_data[n*BW_ACT +: BW_ACT];
      end
   end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl with SRAM, array and buffer models.
// Small geometry: 2x2 array, 3x4 activations, 4x4 weights.
module tb_systolic_tile_ctrl;

   localparam int LEN = 2, WIDTH = 2, IA_H = 3, IA_W = 4, OA_W = 4, RES_LAT = 3;
   localparam int BW = 8, BA = 32, ROW_W = 2, COL_W = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy, done;
   logic wet_rd_en;
   logic [COL_W-1:0] wet_rd_row, wet_rd_col;
   logic [LEN*WIDTH*BW-1:0] wet_rd_data = '0;
   logic [LEN-1:0] act_rd_en;
   logic [LEN*ROW_W-1:0] act_rd_row;
   logic [COL_W-1:0] act_rd_col;
   logic [LEN*BW-1:0] act_rd_data = '0;
   logic pe_mac_enable, pe_clear_acc;
   logic [LEN*BW-1:0] pe_act_in;
   logic [LEN*WIDTH*BW-1:0] pe_wet_in;
   logic [WIDTH*BA-1:0] pe_result_in = '0;
   logic [WIDTH-1:0] out_wr_en;
   logic [WIDTH*ROW_W-1:0] out_wr_row;
   logic [COL_W-1:0] out_wr_col;
   logic out_wr_accum;
   logic [WIDTH*BA-1:0] out_wr_data;

   systolic_tile_ctrl #(
      .LEN(LEN), .WIDTH(WIDTH), .BW_ACT(BW), .BW_WET(BW), .BW_ACCU(BA),
      .IA_H(IA_H), .IA_W(IA_W), .OA_W(OA_W), .RES_LAT(RES_LAT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .done(done),
      .wet_rd_en(wet_rd_en), .wet_rd_row(wet_rd_row),
      .wet_rd_col(wet_rd_col), .wet_rd_data(wet_rd_data),
      .act_rd_en(act_rd_en), .act_rd_row(act_rd_row),
      .act_rd_col(act_rd_col), .act_rd_data(act_rd_data),
      .pe_mac_enable(pe_mac_enable), .pe_clear_acc(pe_clear_acc),
      .pe_act_in(pe_act_in), .pe_wet_in(pe_wet_in),
      .pe_result_in(pe_result_in),
      .out_wr_en(out_wr_en), .out_wr_row(out_wr_row),
      .out_wr_col(out_wr_col), .out_wr_accum(out_wr_accum),
      .out_wr_data(out_wr_data)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   logic [7:0] amem [IA_H][IA_W];
   logic [7:0] wmem [IA_W][OA_W];
   int obuf [IA_H][OA_W];
   int gold [IA_H][OA_W];
   logic [LEN*BW-1:0] hist [64];
   int tcyc = 100;

   // Synchronous-read SRAM models.
   always @(posedge clk) begin
      if (wet_rd_en)
         for (int n = 0; n < LEN; n++)
            for (int p = 0; p < WIDTH; p++)
               wet_rd_data[(n*WIDTH+p)*BW +: BW] <= wmem[int'(wet_rd_row)+n][int'(wet_rd_col)+p];
      for (int n = 0; n < LEN; n++)
         if (act_rd_en[n])
            act_rd_data[n*BW +: BW] <= amem[act_rd_row[n*ROW_W +: ROW_W]][int'(act_rd_col)+n];
   end

   // Behavioural array: column p emits the dot product of the row whose
   // lane-0 activation arrived RES_LAT+p cycles ago; then the output buffer.
   always @(negedge clk) begin
      int acc, a, w, t;
      tcyc++;
      hist[tcyc % 64] = pe_act_in;
      for (int p = 0; p < WIDTH; p++) begin
         acc = 0;
         for (int n = 0; n < LEN; n++) begin
            t = tcyc - RES_LAT - p + n;
            a = int'($signed(hist[t % 64][n*BW +: BW]));
            w = int'($signed(pe_wet_in[(n*WIDTH+p)*BW +: BW]));
            acc += a * w;
         end
         pe_result_in[p*BA +: BA] = acc;
      end
      #1;
      for (int p = 0; p < WIDTH; p++) begin
         if (out_wr_en[p]) begin
            int r, c, d;
            r = int'(out_wr_row[p*ROW_W +: ROW_W]);
            c = int'(out_wr_col) + p;
            d = int'(out_wr_data[p*BA +: BA]);
            if (r < IA_H && c < OA_W)
               obuf[r][c] = out_wr_accum ? obuf[r][c] + d : d;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [1:0] exp_act [10] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
   logic [1:0] exp_oen [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0};
   logic [1:0] exp_col [4]  = '{2'd0, 2'd0, 2'd2, 2'd2};
   logic [1:0] exp_irow [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
   logic       exp_acc [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      int ndone, tile, ph;
      for (int r = 0; r < IA_H; r++)
         for (int k = 0; k < IA_W; k++) amem[r][k] = 8'($urandom);
      for (int k = 0; k < IA_W; k++)
         for (int c = 0; c < OA_W; c++) wmem[k][c] = 8'($urandom);
      for (int r = 0; r < IA_H; r++)
         for (int c = 0; c < OA_W; c++) begin
            gold[r][c] = 0;
            obuf[r][c] = 0;
            for (int k = 0; k < IA_W; k++)
               gold[r][c] += int'($signed(amem[r][k])) * int'($signed(wmem[k][c]));
         end
      for (int q = 0; q < 64; q++) hist[q] = '0;

      // Reset held with start high.
      reset = 1'b0;
      start = 1'b1;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wet_en", wet_rd_en, 0);
      chk("rst_act_en", act_rd_en, 0);
      chk("rst_out_en", out_wr_en, 0);
      chk("rst_mac", pe_mac_enable, 0);
      chk("rst_clr", pe_clear_acc, 0);
      chk("rst_pe_act", pe_act_in, 0);
      chk("rst_pe_wet", pe_wet_in, 0);
      start = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      chk("post_rst_busy", busy, 0);

      // Full job; a stray start at T0+15 must be ignored.
      go();
      ndone = 0;
      for (int k = 0; k <= 41; k++) begin
         tile = k / 10;
         ph = k % 10;
         if (done) ndone++;
         if (k < 40) begin
            chk("j1_busy", busy, 1);
            chk("j1_done", done, 0);
            chk("j1_wet_en", wet_rd_en, ph == 0);
            chk("j1_act_en", act_rd_en, exp_act[ph]);
            chk("j1_out_en", out_wr_en, exp_oen[ph]);
            chk("j1_clr", pe_clear_acc, ph == 9);
            chk("j1_mac", pe_mac_enable, ph >= 2 && ph <= 8);
            if (ph == 0) begin
               chk("j1_wet_row", wet_rd_row, exp_irow[tile]);
               chk("j1_wet_col", wet_rd_col, exp_col[tile]);
            end
            if (ph == 1) chk("j1_act_col", act_rd_col, exp_irow[tile]);
            if (ph >= 2 && ph <= 4)
               chk("j1_act_row1", act_rd_row[ROW_W +: ROW_W], ph - 2);
            if (ph == 5) begin
               chk("j1_out_col", out_wr_col, exp_col[tile]);
               chk("j1_accum", out_wr_accum, exp_acc[tile]);
               chk("j1_row0", out_wr_row[0 +: ROW_W], 0);
            end
            if (ph >= 6 && ph <= 8)
               chk("j1_row1", out_wr_row[ROW_W +: ROW_W], ph - 6);
         end else if (k == 40) begin
            chk("j1_done40", done, 1);
            chk("j1_busy40", busy, 1);
            chk("j1_clr40", pe_clear_acc, 0);
         end else begin
            chk("j1_busy41", busy, 0);
            chk("j1_done41", done, 0);
         end
         start = (k == 14);
         tick();
         start = 1'b0;
      end
      chk("j1_ndone", ndone, 1);
      for (int r = 0; r < IA_H; r++)
         for (int c = 0; c < OA_W; c++)
            chk("e2e_obuf", obuf[r][c], gold[r][c]);

      // Abort mid-job.
      go();
      for (int k = 0; k < 12; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_clr", pe_clear_acc, 1);
      chk("ab_busy13", busy, 1);
      chk("ab_act_en", act_rd_en, 0);
      chk("ab_out_en", out_wr_en, 0);
      chk("ab_wet_en", wet_rd_en, 0);
      chk("ab_mac", pe_mac_enable, 0);
      tick();
      chk("ab_busy14", busy, 0);
      chk("ab_done14", done, 0);
      chk("ab_clr14", pe_clear_acc, 0);

      // Fresh job after abort starts at tile 0 and runs 40 cycles.
      go();
      chk("j3_wet_col", wet_rd_col, 0);
      chk("j3_wet_row", wet_rd_row, 0);
      ndone = 0;
      for (int k = 0; k <= 41; k++) begin
         if (done) begin
            ndone++;
            chk("j3_done_at", k, 40);
         end
         if (k == 41) chk("j3_busy41", busy, 0);
         tick();
      end
      chk("j3_ndone", ndone, 1);

      // Abort and start together in IDLE: stay idle.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abst_busy", busy, 0);

      // Asynchronous reset mid-job.
      go();
      for (int k = 0; k < 25; k++) tick();
      chk("ar_busy_pre", busy, 1);
      reset = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_out_en", out_wr_en, 0);
      chk("ar_act_en", act_rd_en, 0);
      chk("ar_mac", pe_mac_enable, 0);
      chk("ar_clr", pe_clear_acc, 0);
      chk("ar_pe_act", pe_act_in, 0);
      chk("ar_pe_wet", pe_wet_in, 0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("ar_post_out_en", out_wr_en, 0);
         chk("ar_post_busy", busy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
Tile scheduler that sequences one systolic_accu array through a full IA (IA_H x IA_W) times W (IA_W x OA_W) matrix product. It walks output-column tiles (m) and reduction tiles (i), and issues weight and activation SRAM reads. It skews activations into the array, drives mac enable and clear, and emits per-lane output-buffer write strobes with an accumulate flag. It sits between the activation/weight SRAMs, the PE array, and the output accumulation buffer.

Parameters:
LEN, 5, array rows (reduction lanes); IA_W % LEN == 0
WIDTH, 4, array columns; OA_W % WIDTH == 0
BW_ACT, 8, activation bits
BW_WET, 8, weight bits
BW_ACCU, 32, accumulator bits
IA_H, 100, activation rows (= OA_H)
IA_W, 150, reduction depth
OA_W, 16, output columns
RES_LAT, 6, cycles from row0/lane0 act on pe_act_in to row0/col0 result on pe_result_in
ROW_W, $clog2(IA_H), row index width
COL_W, $clog2(IA_W), column index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  begin job; sampled only in IDLE
abort  in  1  synchronous job cancel
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
wet_rd_en  out  1  weight block read (LEN x WIDTH block)
wet_rd_row  out  COL_W  i*LEN
wet_rd_col  out  COL_W  m*WIDTH
wet_rd_data  in  LEN*WIDTH*BW_WET  valid 1 cycle after wet_rd_en
act_rd_en  out  LEN  per-lane read enable
act_rd_row  out  LEN*ROW_W  per-lane row, lane n = j-n
act_rd_col  out  COL_W  i*LEN (lane n reads col +n)
act_rd_data  in  LEN*BW_ACT  valid 1 cycle after act_rd_en
pe_mac_enable  out  1  array enable
pe_clear_acc  out  1  array accumulator clear
pe_act_in  out  LEN*BW_ACT  skewed activations
pe_wet_in  out  LEN*WIDTH*BW_WET  held weights
pe_result_in  in  WIDTH*BW_ACCU  array results
out_wr_en  out  WIDTH  per-column write strobe
out_wr_row  out  WIDTH*ROW_W  column p row = s-p
out_wr_col  out  COL_W  m*WIDTH (column p writes col +p)
out_wr_accum  out  1  0: overwrite; 1: add to buffer
out_wr_data  out  WIDTH*BW_ACCU  pe_result_in passed through, same cycle

Behaviour:
- Reset: all outputs 0; FSM in IDLE; m = i = 0.
- FSM: IDLE -> WLOAD -> FEED -> DRAIN -> CLEAR -> (next tile: WLOAD | last: DONE) -> IDLE.
- Tile order: m outer 0..OA_W/WIDTH-1, i inner 0..IA_W/LEN-1. out_wr_accum = (i != 0).
- Tile start cycle T (WLOAD): wet_rd_en=1. Data is registered into pe_wet_in at T+1 and held until the next WLOAD capture.
- FEED, cycles T+1 .. T+IA_H+LEN-1, step j = 0..IA_H+LEN-2: act_rd_en[n] = (n <= j <= n+IA_H-1), row j-n.
- pe_act_in for step j is registered at T+2+j. Lanes with act_rd_en=0 drive 0. Outside steps pe_act_in = 0.
- pe_mac_enable = 1 from T+2 through last collect cycle; otherwise 0.
- Collect step s = 0..IA_H+WIDTH-2 at cycle T+2+RES_LAT+s: out_wr_en[p] = (p <= s <= p+IA_H-1), row s-p.
- DRAIN lasts until the last collect step.
- CLEAR: one cycle at T+2+RES_LAT+IA_H+WIDTH-1. pe_clear_acc=1, pe_mac_enable=0.
- Tile period P = RES_LAT+IA_H+WIDTH+2. Next WLOAD immediately follows CLEAR.
- start accepted at edge E0: busy=1 from the next cycle (T0). After the last CLEAR, DONE: done=1 for 1 cycle at T0 + tiles*P, busy still 1. Then IDLE with busy=0.
- start while busy: ignored.
- abort in any non-IDLE state: next cycle is CLEAR (pe_clear_acc=1, all rd/wr enables 0), then IDLE. No done pulse; m and i reset.
- abort and start together in IDLE: abort wins (stay IDLE).
- Asynchronous reset mid-job: immediate return to reset state; no partial writes after deassertion.

Test Plan:
(Bench params: LEN=2, WIDTH=2, IA_H=3, IA_W=4, OA_W=4, RES_LAT=3 -> P=10, tiles=4.)
- Reset: hold reset=0 with start=1 -> all outputs 0, busy=0; after release, busy is still 0 until start is pulsed.
- Single start at E0 -> wet_rd_en at T0 only; act_rd_en = 01,11,11,10 over T0+1..T0+4; pe_clear_acc at T0+9; done at T0+40; busy drops at T0+41.
- Lane masking, tile 0 -> out_wr_en = 01,11,11,10 at T0+5..T0+8; column-1 rows 0,1,2 at T0+6..T0+8; out_wr_col = 0,0,2,2 and out_wr_accum = 0,1,0,1 across tiles.
- End to end: drive a behavioural PE array and SRAMs with random int8 data -> output buffer equals the golden IA x W product, with 0 mismatches.
- start pulsed at T0+15 -> ignored; done still at T0+40 and exactly one done pulse.
- abort at T0+12 -> pe_clear_acc=1 at T0+13, busy=0 at T0+14, no done; a new start then runs a full 40-cycle job. reset=0 at T0+25 -> outputs 0 immediately.
